// File: rtl/ddr_app_sequencer.sv
// Single-transaction sequencer from the DDR bus arbiter to the MIG 7-series app interface.
// Optional watchdog is compiled in when DDR_APP_TIMEOUT_EN is defined.
module ddr_app_sequencer #(
    parameter int unsigned ADDR_WIDTH     = 28,
    parameter int unsigned DATA_WIDTH     = 128,
    parameter int unsigned MASK_WIDTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_166M66,
    input  logic                  mcu_sys_rst,
    input  logic                  i_init_calib_complete,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_rw,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    input  logic [MASK_WIDTH-1:0] i_req_wmask,
    output logic                  o_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                  o_timeout_err,
    output logic [ADDR_WIDTH-1:0] o_app_addr,
    output logic [2:0]            o_app_cmd,
    output logic                  o_app_en,
    input  logic                  i_app_rdy,
    output logic [DATA_WIDTH-1:0] o_app_wdf_data,
    output logic [MASK_WIDTH-1:0] o_app_wdf_mask,
    output logic                  o_app_wdf_wren,
    output logic                  o_app_wdf_end,
    input  logic                  i_app_wdf_rdy,
    input  logic [DATA_WIDTH-1:0] i_app_rd_data,
    input  logic                  i_app_rd_data_valid
);

    localparam logic [2:0] CmdWrite = 3'b000;
    localparam logic [2:0] CmdRead  = 3'b001;

    typedef enum logic [2:0] {StIdle, StWr, StRd, StRdWait, StDone} state_e;

    state_e                state_q, state_d;
    logic                  ready_q, ready_d;
    logic                  app_en_q, app_en_d;
    logic                  wren_q, wren_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            cmd_q, cmd_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [MASK_WIDTH-1:0] wmask_q, wmask_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  terr_q, terr_d;
    logic                  tout_q, tout_d;
    logic                  accept;
    logic                  expire;

    assign accept = (state_q == StIdle) && i_req_valid && ready_q;

`ifdef DDR_APP_TIMEOUT_EN
    localparam int unsigned CntWidth = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(TIMEOUT_CYCLES - 1);

    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                busy;

    assign busy   = (state_q == StWr) || (state_q == StRd) || (state_q == StRdWait);
    assign expire = busy && (cnt_q == CntLast);

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = '0;
        end else if (busy) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_166M66) begin
        if (mcu_sys_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign expire         = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        ready_d     = 1'b0;
        app_en_d    = app_en_q;
        wren_d      = wren_q;
        addr_d      = addr_q;
        cmd_d       = cmd_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        rsp_valid_d = 1'b0;
        rdata_d     = rdata_q;
        terr_d      = 1'b0;
        tout_d      = tout_q;

        unique case (state_q)
            StIdle: begin
                ready_d = i_init_calib_complete;
                if (accept) begin
                    ready_d  = 1'b0;
                    addr_d   = i_req_addr;
                    cmd_d    = i_req_rw ? CmdWrite : CmdRead;
                    wdata_d  = i_req_wdata;
                    wmask_d  = i_req_wmask;
                    app_en_d = 1'b1;
                    wren_d   = i_req_rw;
                    tout_d   = 1'b0;
                    state_d  = i_req_rw ? StWr : StRd;
                end
            end
            StWr: begin
                // Command and data handshakes retire independently.
                if (app_en_q && i_app_rdy) begin
                    app_en_d = 1'b0;
                end
                if (wren_q && i_app_wdf_rdy) begin
                    wren_d = 1'b0;
                end
                if (!app_en_d && !wren_d) begin
                    state_d = StDone;
                end
            end
            StRd: begin
                if (i_app_rdy) begin
                    app_en_d = 1'b0;
                    state_d  = StRdWait;
                end
            end
            StRdWait: begin
                if (i_app_rd_data_valid) begin
                    rdata_d = i_app_rd_data;
                    state_d = StDone;
                end
            end
            StDone: begin
                rsp_valid_d = 1'b1;
                terr_d      = tout_q;
                ready_d     = i_init_calib_complete;
                state_d     = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A handshake completing on the expiry edge still counts as a normal finish.
        if (expire && (state_d != StDone)) begin
            app_en_d = 1'b0;
            wren_d   = 1'b0;
            tout_d   = 1'b1;
            state_d  = StDone;
        end
    end

    always_ff @(posedge clk_166M66) begin
        if (mcu_sys_rst) begin
            state_q     <= StIdle;
            ready_q     <= 1'b0;
            app_en_q    <= 1'b0;
            wren_q      <= 1'b0;
            addr_q      <= '0;
            cmd_q       <= 3'b000;
            wdata_q     <= '0;
            wmask_q     <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            terr_q      <= 1'b0;
            tout_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            app_en_q    <= app_en_d;
            wren_q      <= wren_d;
            addr_q      <= addr_d;
            cmd_q       <= cmd_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            terr_q      <= terr_d;
            tout_q      <= tout_d;
        end
    end

    assign o_req_ready    = ready_q;
    assign o_rsp_valid    = rsp_valid_q;
    assign o_rsp_rdata    = rdata_q;
    assign o_timeout_err  = terr_q;
    assign o_app_addr     = addr_q;
    assign o_app_cmd      = cmd_q;
    assign o_app_en       = app_en_q;
    assign o_app_wdf_data = wdata_q;
    assign o_app_wdf_mask = wmask_q;
    assign o_app_wdf_wren = wren_q;
    assign o_app_wdf_end  = wren_q;

endmodule
